// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
//   state_t          : FSM state encoding (IDLE / WAIT / RESP)
//   MISALIGN_MASK    : byte-offset bits that must be zero for a word access
//   DEFAULT_DEPTH    : default number of 32-bit words
//   DEFAULT_WAIT_CYC : default wait-state count between accept and response
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] MISALIGN_MASK    = 2'b11;
  localparam int         DEFAULT_DEPTH    = 64;
  localparam int         DEFAULT_WAIT_CYC = 2;

endpackage

// File: rtl/data_mem_responder_addr_check.sv
// Address decode for the data memory responder.
// Ports:
//   i_addr     : byte address of the request
//   o_word_idx : word index into the memory array (addr[2 +: IDX_W])
//   o_err      : misaligned (addr[1:0] != 0) or word index beyond DEPTH
module dmem_addr_check
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [31:0]      i_addr,
  output logic [IDX_W-1:0] o_word_idx,
  output logic             o_err
);

  logic w_misaligned;
  logic w_out_of_range;

  assign w_misaligned   = |(i_addr[1:0] & MISALIGN_MASK);
  // Compare the full word address so that high address bits cannot alias
  // back into the array.
  assign w_out_of_range = (i_addr[31:2] >= 30'(DEPTH));
  assign o_word_idx     = i_addr[2 +: IDX_W];
  assign o_err          = w_misaligned | w_out_of_range;

endmodule

// File: rtl/data_mem_responder.sv
// Word-wide data memory with a valid/ready request channel and a
// valid/ready response channel, one request outstanding at a time.
// Ports:
//   clock, reset_n           : clock, async active-low reset
//   req_valid / req_ready    : request handshake (ready only in IDLE)
//   req_we, req_addr,
//   req_wdata                : store flag, byte address, store data
//   resp_valid / resp_ready  : response handshake (valid only in RESP)
//   resp_rdata, resp_err     : load data / error flag, zero outside RESP
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request
// WAIT  | request latched, counting down wait states
// RESP  | response presented, held until resp_ready
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int WAIT_CYC = DEFAULT_WAIT_CYC
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_wait_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH];

  logic             w_accept;
  logic             w_enter_resp;
  logic             w_acc_we;
  logic [31:0]      w_acc_addr;
  logic [31:0]      w_acc_wdata;
  logic [IDX_W-1:0] w_word_idx;
  logic             w_addr_err;

  assign w_accept     = (r_state == ST_IDLE) && req_valid;
  assign w_enter_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);

  // With no wait states the access happens on the accept edge itself, so
  // the live request fields are used; otherwise the latched copies.
  assign w_acc_we    = (r_state == ST_IDLE) ? req_we    : r_we;
  assign w_acc_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

  dmem_addr_check #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_addr_check (
    .i_addr     (w_acc_addr),
    .o_word_idx (w_word_idx),
    .o_err      (w_addr_err)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next_state = (WAIT_CYC == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_wait_cnt == 4'd0) w_next_state = ST_RESP;
      ST_RESP: if (resp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = (r_state == ST_RESP);
    resp_rdata = (r_state == ST_RESP) ? r_rdata : 32'd0;
    resp_err   = (r_state == ST_RESP) ? r_err   : 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 4'd0;
    end else if (w_accept) begin
      r_wait_cnt <= WAIT_LOAD;
    end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_enter_resp) begin
      if (w_addr_err) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b1;
      end else if (w_acc_we) begin
        r_mem[w_word_idx] <= w_acc_wdata;
        r_rdata           <= 32'd0;
        r_err             <= 1'b0;
      end else begin
        r_rdata <= r_mem[w_word_idx];
        r_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance 0 uses WAIT_CYC=2, instance 1 uses WAIT_CYC=0.
module tb_data_mem_responder;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_err;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_responder #(.DEPTH(64), .WAIT_CYC(2)) u_dut_w2 (
    .clock      (clock),
    .reset_n    (reset_n[0]),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_we     (req_we[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0])
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYC(0)) u_dut_w0 (
    .clock      (clock),
    .reset_n    (reset_n[1]),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_we     (req_we[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction with resp_ready held high. Latency is the index of
  // the first edge (accept edge = 0) at which resp_valid is seen high.
  task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input string tag);
    int lat;
    @(negedge clock);
    check_val({tag, " req_ready"}, 32'(req_ready[k]), 32'd1);
    req_valid[k]  = 1'b1;
    req_we[k]     = we;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    resp_ready[k] = 1'b1;
    @(posedge clock);
    #1 req_valid[k] = 1'b0;
    lat = 1;
    while (lat <= 40) begin
      @(negedge clock);
      if (resp_valid[k]) break;
      lat++;
    end
    check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, " err"}, 32'(resp_err[k]), 32'(exp_err));
    check_val({tag, " rdata"}, resp_rdata[k], exp_rdata);
    @(posedge clock);
    #1;
    check_val({tag, " idle valid"}, 32'(resp_valid[k]), 32'd0);
    check_val({tag, " idle rdata"}, resp_rdata[k], 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    reset_n    = 2'b11;
    req_valid  = 2'b00;
    req_we     = 2'b00;
    resp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
    end
    #2 reset_n = 2'b00;
    #2;
    check_val("rst req_ready",  32'(req_ready[0]),  32'd1);
    check_val("rst resp_valid", 32'(resp_valid[0]), 32'd0);
    check_val("rst resp_rdata", resp_rdata[0],       32'd0);
    check_val("rst resp_err",   32'(resp_err[0]),    32'd0);
    repeat (2) @(negedge clock);
    reset_n = 2'b11;

    do_req(0, 1'b1, 32'h10,  32'hDEADBEEF, 3, 1'b0, 32'h0,        "sw10");
    do_req(0, 1'b0, 32'h10,  32'h0,        3, 1'b0, 32'hDEADBEEF, "lw10");
    do_req(0, 1'b0, 32'h13,  32'h0,        3, 1'b1, 32'h0,        "lw13");
    do_req(0, 1'b0, 32'h10,  32'h0,        3, 1'b0, 32'hDEADBEEF, "lw10b");
    do_req(0, 1'b1, 32'h100, 32'h55AA55AA, 3, 1'b1, 32'h0,        "sw100");
    do_req(0, 1'b0, 32'hFC,  32'h0,        3, 1'b0, 32'h0,        "lwFC");
    do_req(0, 1'b0, 32'h0,   32'h0,        3, 1'b0, 32'h0,        "lw00");
    do_req(0, 1'b1, 32'hFC,  32'h0BADCAFE, 3, 1'b0, 32'h0,        "swFC");
    do_req(0, 1'b0, 32'hFC,  32'h0,        3, 1'b0, 32'h0BADCAFE, "lwFCb");

    // Response held off for five cycles; a stray store stays asserted and
    // must be ignored while the load is outstanding.
    @(negedge clock);
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b0;
    req_addr[0]   = 32'h10;
    resp_ready[0] = 1'b0;
    @(posedge clock);
    #1;
    req_we[0]    = 1'b1;
    req_wdata[0] = 32'h11111111;
    lat = 1;
    while (lat <= 40) begin
      @(negedge clock);
      if (resp_valid[0]) break;
      lat++;
    end
    check_val("hold latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      check_val("hold valid", 32'(resp_valid[0]), 32'd1);
      check_val("hold rdata", resp_rdata[0],       32'hDEADBEEF);
      check_val("hold err",   32'(resp_err[0]),    32'd0);
      check_val("hold ready", 32'(req_ready[0]),   32'd0);
    end
    resp_ready[0] = 1'b1;
    req_valid[0]  = 1'b0;
    @(posedge clock);
    #1;
    check_val("hold exit valid", 32'(resp_valid[0]), 32'd0);
    check_val("hold exit ready", 32'(req_ready[0]),  32'd1);
    do_req(0, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, "lw10 after stray");

    // Reset while a store waits: aborted, and memory is cleared.
    @(negedge clock);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h00001234;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    @(negedge clock);
    reset_n[0] = 1'b0;
    #1;
    check_val("wait rst ready", 32'(req_ready[0]),  32'd1);
    check_val("wait rst valid", 32'(resp_valid[0]), 32'd0);
    #1 reset_n[0] = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (resp_valid[0]) seen = 1'b1;
    end
    check_val("wait rst no resp", 32'(seen), 32'd0);
    do_req(0, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h0, "lw20 after rst");
    do_req(0, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'h0, "lw10 after rst");

    // Zero wait states.
    do_req(1, 1'b1, 32'h8, 32'hA5A50F0F, 1, 1'b0, 32'h0,        "w0 sw8");
    do_req(1, 1'b0, 32'h8, 32'h0,        1, 1'b0, 32'hA5A50F0F, "w0 lw8");
    do_req(1, 1'b0, 32'h9, 32'h0,        1, 1'b1, 32'h0,        "w0 lw9");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
